// File: rtl/updn_counter_pkg.sv
// Shared constants for the prescaled up/down counter.
// Direction and terminal-mode encodings plus default widths.
package updn_counter_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_PRE_W = 4;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles down to one tick every prescale+1 of them.
// A value above prescale (prescale lowered mid-run) restarts at 0.
module tick_prescaler
    import updn_counter_pkg::*;
#(
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] cnt;

    assign tick = enable && (cnt == prescale);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt >= prescale)
                cnt <= '0;
            else
                cnt <= cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/updn_counter.sv
// Prescaled up/down counter with wrap/saturate terminal handling,
// a one-cycle terminal pulse and a sticky overflow flag.
module updn_counter
    import updn_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up,
    input  logic             sat,
    input  logic [WIDTH-1:0] modulus,
    input  logic [PRE_W-1:0] prescale,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic             tick;
    logic             term;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_lim;

    tick_prescaler #(
        .PRE_W(PRE_W)
    ) u_pre (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .clr     (load),
        .prescale(prescale),
        .tick    (tick)
    );

    assign load_lim = (load_val > modulus) ? modulus : load_val;

    always_comb begin
        next_count = count;
        term       = 1'b0;
        if (tick) begin
            if (up == DIR_UP) begin
                if (count < modulus)
                    next_count = count + WIDTH'(1);
                else
                    term = 1'b1;
            end else begin
                if (count == '0)
                    term = 1'b1;
                else if (count > modulus)
                    next_count = modulus;
                else
                    next_count = count - WIDTH'(1);
            end
            // Terminal target: wrap jumps to the far end, saturate stays put
            if (term) begin
                if (sat == MODE_SAT)
                    next_count = (up == DIR_UP) ? modulus : '0;
                else
                    next_count = (up == DIR_UP) ? '0 : modulus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                count <= load_lim;
                tc    <= 1'b0;
            end else begin
                count <= next_count;
                tc    <= term;
            end
            if (term && !load)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updn_counter.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs,
// a monitor pops and compares them on each falling edge.
module tb_updn_counter;

    localparam int WIDTH = 8;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             up;
    logic             sat;
    logic [WIDTH-1:0] modulus;
    logic [PRE_W-1:0] prescale;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    typedef struct {
        int c;
        bit t;
        bit o;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    int m_count = 0;
    int m_pre = 0;
    bit m_tc = 0;
    bit m_ovf = 0;

    updn_counter #(
        .WIDTH(WIDTH),
        .PRE_W(PRE_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .up      (up),
        .sat     (sat),
        .modulus (modulus),
        .prescale(prescale),
        .load    (load),
        .load_val(load_val),
        .clr_ovf (clr_ovf),
        .count   (count),
        .tc      (tc),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour evaluated from the inputs seen at this edge
    task automatic model();
        int  m;
        int  p;
        bit  tk;
        bit  term;
        m    = int'(modulus);
        p    = int'(prescale);
        term = 0;
        if (!rst_n) begin
            m_count = 0;
            m_pre   = 0;
            m_tc    = 0;
            m_ovf   = 0;
            return;
        end
        tk = enable && (m_pre == p);
        if (load)
            m_pre = 0;
        else if (enable)
            m_pre = (m_pre >= p) ? 0 : m_pre + 1;
        if (load) begin
            m_count = (int'(load_val) < m) ? int'(load_val) : m;
        end else if (tk) begin
            if (up) begin
                if (m_count < m) m_count++;
                else term = 1;
            end else begin
                if (m_count == 0) term = 1;
                else if (m_count > m) m_count = m;
                else m_count--;
            end
            if (term) begin
                if (sat) m_count = up ? m : 0;
                else m_count = up ? 0 : m;
            end
        end
        m_tc = term;
        if (term) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model();
        e.c = m_count;
        e.t = m_tc;
        e.o = m_ovf;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_count", int'(count), e.c);
                chk("sb_tc", int'(tc), int'(e.t));
                chk("sb_ovf", int'(ovf), int'(e.o));
            end
        end
    end

    initial begin : stim
        rst_n    = 1'b0;
        enable   = 1'b0;
        up       = 1'b1;
        sat      = 1'b0;
        modulus  = 8'd9;
        prescale = '0;
        load     = 1'b0;
        load_val = '0;
        clr_ovf  = 1'b0;
        step();
        step();
        chk("reset_count", int'(count), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_ovf", int'(ovf), 0);
        rst_n = 1'b1;

        // Wrap upward through modulus 9
        enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("wrap_up_count", int'(count), i);
        end
        step();
        chk("wrap_to_zero", int'(count), 0);
        chk("wrap_tc", int'(tc), 1);
        chk("wrap_ovf", int'(ovf), 1);
        step();
        chk("wrap_tc_gone", int'(tc), 0);
        chk("wrap_next", int'(count), 1);

        // Saturate downward from a load of 2
        enable   = 1'b0;
        modulus  = 8'd5;
        up       = 1'b0;
        sat      = 1'b1;
        load     = 1'b1;
        load_val = 8'd2;
        clr_ovf  = 1'b1;
        step();
        load    = 1'b0;
        clr_ovf = 1'b0;
        chk("sat_load", int'(count), 2);
        chk("sat_ovf_clr", int'(ovf), 0);
        enable = 1'b1;
        step();
        chk("sat_dn1", int'(count), 1);
        step();
        chk("sat_dn0", int'(count), 0);
        chk("sat_no_tc", int'(tc), 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("sat_hold0", int'(count), 0);
            chk("sat_tc", int'(tc), 1);
            chk("sat_ovf", int'(ovf), 1);
        end
        enable  = 1'b0;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf", int'(ovf), 0);

        // Prescale 3 with an enable gap
        modulus  = 8'd100;
        up       = 1'b1;
        sat      = 1'b0;
        prescale = 4'd3;
        load     = 1'b1;
        load_val = 8'd0;
        step();
        load   = 1'b0;
        enable = 1'b1;
        repeat (4) step();
        chk("pre_first", int'(count), 1);
        repeat (3) step();
        chk("pre_hold", int'(count), 1);
        step();
        chk("pre_second", int'(count), 2);
        repeat (2) step();
        enable = 1'b0;
        repeat (2) step();
        enable = 1'b1;
        step();
        chk("gap_hold", int'(count), 2);
        step();
        chk("gap_step", int'(count), 3);

        // Load clamps to modulus; load beats a coincident tick
        prescale = 4'd0;
        enable   = 1'b0;
        load     = 1'b1;
        load_val = 8'd200;
        step();
        chk("load_clamp", int'(count), 100);
        enable   = 1'b1;
        load_val = 8'd7;
        step();
        load = 1'b0;
        chk("load_vs_tick", int'(count), 7);
        chk("load_vs_tick_tc", int'(tc), 0);

        // Modulus lowered below count, down tick snaps to modulus
        enable   = 1'b0;
        load     = 1'b1;
        load_val = 8'd50;
        step();
        load    = 1'b0;
        modulus = 8'd20;
        up      = 1'b0;
        enable  = 1'b1;
        step();
        enable = 1'b0;
        chk("snap_count", int'(count), 20);
        chk("snap_tc", int'(tc), 0);
        chk("snap_ovf", int'(ovf), 0);

        // Reset mid-run overrides everything
        up       = 1'b1;
        prescale = 4'd3;
        enable   = 1'b1;
        step();
        load     = 1'b1;
        load_val = 8'd9;
        clr_ovf  = 1'b1;
        rst_n    = 1'b0;
        step();
        rst_n   = 1'b1;
        load    = 1'b0;
        clr_ovf = 1'b0;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_tc", int'(tc), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        repeat (3) step();
        chk("post_rst_wait", int'(count), 0);
        step();
        chk("post_rst_tick", int'(count), 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            enable  = ($urandom_range(0, 3) != 0);
            load    = ($urandom_range(0, 15) == 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            load_val = WIDTH'($urandom_range(0, 24));
            if ($urandom_range(0, 15) == 0) up = ~up;
            if ($urandom_range(0, 15) == 0) sat = ~sat;
            if ($urandom_range(0, 31) == 0)
                modulus = WIDTH'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0)
                prescale = PRE_W'($urandom_range(0, 3));
            step();
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
